// File: rtl/shift_pkg.sv
// Shared definitions for the parameterised shift register: operation modes.
package shift_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'b00,
      SHL  = 2'b01,
      SHR  = 2'b10,
      LOAD = 2'b11
   } mode_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Serialize-frame sequencer: counts WIDTH busy cycles, then pulses done once.
module shift_bit_counter #(
   parameter  int WIDTH = 8,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   output logic shift_en
);

   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Starts arriving while busy are dropped; the done cycle is idle, so a
   // held start restarts on the edge that ends it.
   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      cnt_d  = cnt_q;
      if (busy_q) begin
         if (cnt_q == CNT_MAX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign shift_en = busy_q && (cnt_q != CNT_MAX);

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised shift register with hold/shift/load modes and an MSB-first
// serializer frame started by a single-cycle start request.
module param_shift_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] par_in,
   input  logic             sin_lsb,
   input  logic             sin_msb,
   input  logic             start,
   output logic [WIDTH-1:0] par_out,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             shift_en;

   shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .shift_en (shift_en)
   );

   // While a frame runs, mode and start have no effect on the datapath.
   always_comb begin
      q_d = q_q;
      if (busy) begin
         if (shift_en) q_d = {q_q[WIDTH-2:0], sin_lsb};
      end else if (start) begin
         q_d = par_in;
      end else begin
         case (mode_e'(mode))
            HOLD:    q_d = q_q;
            SHL:     q_d = {q_q[WIDTH-2:0], sin_lsb};
            SHR:     q_d = {sin_msb, q_q[WIDTH-1:1]};
            LOAD:    q_d = par_in;
            default: q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_q <= '0;
      else        q_q <= q_d;
   end

   assign par_out  = q_q;
   assign sout_msb = q_q[WIDTH-1];
   assign sout_lsb = q_q[0];

endmodule

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-low; the block SHALL clear when reset is low.
REQ-004 Port mode  input  2  operation select when idle: HOLD, SHL, SHR or LOAD.
REQ-005 Port par_in  input  WIDTH  parallel load data.
REQ-006 Port sin_lsb  input  1  serial bit entering bit 0 on left shifts.
REQ-007 Port sin_msb  input  1  serial bit entering bit WIDTH-1 on right shifts.
REQ-008 Port start  input  1  single-cycle request to load par_in and serialize it MSB-first.
REQ-009 Port par_out  output  WIDTH  current register contents q.
REQ-010 Port sout_msb  output  1  q[WIDTH-1], combinational from q.
REQ-011 Port sout_lsb  output  1  q[0], combinational from q.
REQ-012 Port busy  output  1  registered; high while a serialize frame runs.
REQ-013 Port done  output  1  registered; one-cycle pulse at frame end.

Function
REQ-014 When idle (busy=0) and start=0, the block SHALL act on mode per edge:
- HOLD: q unchanged.
- SHL: q <= {q[WIDTH-2:0], sin_lsb}.
- SHR: q <= {sin_msb, q[WIDTH-1:1]}.
- LOAD: q <= par_in.
REQ-015 When idle and start=1, the edge SHALL do q <= par_in, busy <= 1, cnt <= 0; start SHALL take priority over mode.
REQ-016 While busy, each edge SHALL do one of:
- cnt < WIDTH-1: q shifts left with sin_lsb, cnt increments.
- cnt == WIDTH-1: q holds, busy <= 0, done <= 1.
REQ-017 busy SHALL be high for exactly WIDTH cycles; in busy cycle k (k = 0..WIDTH-1), sout_msb SHALL equal par_in[WIDTH-1-k].
REQ-018 done SHALL be high for exactly one cycle, the cycle immediately after busy's last cycle; otherwise low.
REQ-019 While busy, mode and start SHALL be ignored.
- A start sampled on busy's last edge SHALL be dropped.
- The earliest accepted restart is the edge that ends the done cycle, so frames are separated by at least one idle cycle.
REQ-020 cnt SHALL be $clog2(WIDTH) bits wide and never exceed WIDTH-1.

Reset
REQ-021 reset low SHALL immediately, without waiting for clk, force q=0, cnt=0, busy=0, done=0, including mid-frame.
REQ-022 After reset deasserts, the first edge SHALL behave as idle; any frame in progress at reset SHALL be abandoned, not resumed.

Structure
REQ-023 Package shift_pkg SHALL hold the mode enum typedef: HOLD=2'b00, SHL=2'b01, SHR=2'b10, LOAD=2'b11.
REQ-024 Frame sequencing (cnt, busy, done) SHALL sit in one sub-module, shift_bit_counter, parameterised by WIDTH; the datapath stays in param_shift_reg.

Verification (WIDTH=8)
REQ-025 Reset: assert reset low mid-frame between clock edges -> par_out=8'h00, busy=0, done=0 immediately.
REQ-026 LOAD 8'hA5, then three SHL with sin_lsb=1 -> par_out sequence 8'hA5, 8'h4B, 8'h97, 8'h2F.
REQ-027 LOAD 8'hA5, then two SHR with sin_msb=0 -> 8'h52, then 8'h29; HOLD afterwards keeps 8'h29.
REQ-028 start with par_in=8'hC3 -> busy high 8 cycles; sout_msb = 1,1,0,0,0,0,1,1; done pulses once in the 9th cycle.
REQ-029 During the 8'hC3 frame, pulse start with par_in=8'hFF and drive mode=LOAD -> both ignored; bit sequence unchanged.
REQ-030 Hold start high continuously -> frames repeat with exactly one idle (done) cycle between busy windows.
